// File: rtl/clock_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_pkg
// Brief    : Shared state encodings and limits for the clock divider control.
// Revision : 1.0 - initial release
// ============================================================================
package clock_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int MIN_RATIO = 2;

endpackage
`default_nettype wire

// File: rtl/clock_div_core.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_core
// Brief    : Divide counter with registered clk_out/tick and active-ratio store.
// Revision : 1.0 - initial release
// ============================================================================
module clock_div_core #(
    parameter int COUNT_REG_SIZE = 8,
    parameter int DEFAULT_RATIO  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      restart,
    input  logic                      load,
    input  logic [COUNT_REG_SIZE-1:0] ratio_in,
    output logic                      boundary,
    output logic                      clk_out,
    output logic                      tick
);

    localparam logic [COUNT_REG_SIZE-1:0] c_one = {{(COUNT_REG_SIZE-1){1'b0}}, 1'b1};

    logic [COUNT_REG_SIZE-1:0] r_ratio;
    logic [COUNT_REG_SIZE-1:0] r_cnt;
    logic                      r_clk_out;
    logic                      r_tick;
    logic [COUNT_REG_SIZE-1:0] w_half;
    logic [COUNT_REG_SIZE-1:0] w_last;
    logic [COUNT_REG_SIZE-1:0] w_cnt_inc;

    // (N+1)>>1 computed without needing a wider intermediate
    assign w_half    = (r_ratio >> 1) + {{(COUNT_REG_SIZE-1){1'b0}}, r_ratio[0]};
    assign w_last    = r_ratio - c_one;
    assign w_cnt_inc = r_cnt + c_one;
    assign boundary  = en && (r_cnt == w_last);
    assign clk_out   = r_clk_out;
    assign tick      = r_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ratio   <= COUNT_REG_SIZE'(DEFAULT_RATIO);
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            if (load) begin
                r_ratio <= ratio_in;
            end
            if (en && !boundary) begin
                r_cnt     <= w_cnt_inc;
                r_clk_out <= (w_cnt_inc < w_half);
                r_tick    <= 1'b0;
            end else begin
                // idle or period end: restart begins a fresh period, else hold low
                r_cnt     <= '0;
                r_clk_out <= restart;
                r_tick    <= restart;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_ctrl
// Brief    : Run/stop sequencing and ratio handshake around clock_div_core.
// Revision : 1.0 - initial release
// ============================================================================
module clock_div_ctrl
    import clock_div_pkg::*;
#(
    parameter int COUNT_REG_SIZE = 8,
    parameter int DEFAULT_RATIO  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic                      cfg_valid,
    input  logic [COUNT_REG_SIZE-1:0] cfg_ratio,
    output logic                      cfg_ready,
    output logic                      cfg_err,
    output logic                      clk_out,
    output logic                      tick,
    output logic                      busy
);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [COUNT_REG_SIZE-1:0] r_pend;
    logic                      r_err;
    logic                      w_xfer;
    logic                      w_legal;
    logic                      w_accept;
    logic                      w_load;
    logic                      w_store_pend;
    logic                      w_boundary;
    logic [COUNT_REG_SIZE-1:0] w_ratio_in;

    assign cfg_ready  = (r_state != PEND);
    assign busy       = (r_state == RUN) || (r_state == PEND);
    assign cfg_err    = r_err;
    assign w_xfer     = cfg_valid && cfg_ready;
    assign w_legal    = (cfg_ratio >= COUNT_REG_SIZE'(MIN_RATIO));
    assign w_accept   = w_xfer && w_legal;
    assign w_ratio_in = (r_state == PEND) ? r_pend : cfg_ratio;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_store_pend = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = w_accept;
                if (run) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                // a ratio accepted on the final cycle of a period applies to the next one
                if (w_boundary) begin
                    w_load       = w_accept;
                    w_state_next = run ? RUN : IDLE;
                end else if (w_accept) begin
                    w_store_pend = 1'b1;
                    w_state_next = PEND;
                end
            end
            PEND: begin
                if (w_boundary) begin
                    w_load       = 1'b1;
                    w_state_next = run ? RUN : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_store_pend) begin
                r_pend <= cfg_ratio;
            end
            r_err <= w_xfer && !w_legal;
        end
    end

    clock_div_core #(
        .COUNT_REG_SIZE (COUNT_REG_SIZE),
        .DEFAULT_RATIO  (DEFAULT_RATIO)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .en       (busy),
        .restart  (run),
        .load     (w_load),
        .ratio_in (w_ratio_in),
        .boundary (w_boundary),
        .clk_out  (clk_out),
        .tick     (tick)
    );

endmodule
`default_nettype wire

// File: tb/tb_clock_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_div_ctrl
// Brief    : Scoreboard bench for clock_div_ctrl against a cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_div_ctrl;

    logic       clk;
    logic       reset;
    logic       run;
    logic       cfg_valid;
    logic [7:0] cfg_ratio;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_out;
    logic       tick;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic clk_out;
        logic tick;
        logic busy;
        logic ready;
        logic err;
    } exp_t;

    exp_t sb[$];

    // reference model state: 0=IDLE 1=RUN 2=PEND
    int m_state;
    int m_n;
    int m_pend;
    int m_cnt;
    bit m_clk;
    bit m_tick;
    bit m_err;

    clock_div_ctrl #(
        .COUNT_REG_SIZE (8),
        .DEFAULT_RATIO  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_ratio (cfg_ratio),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_n     = 4;
        m_pend  = 0;
        m_cnt   = 0;
        m_clk   = 0;
        m_tick  = 0;
        m_err   = 0;
    endtask

    task automatic model_step(input bit r, input bit v, input int ratio);
        bit xfer;
        bit ok;
        int h;
        xfer  = v && (m_state != 2);
        ok    = (ratio >= 2);
        h     = (m_n + 1) / 2;
        m_err = xfer && !ok;
        if (m_state == 0) begin
            if (xfer && ok) m_n = ratio;
            m_cnt  = 0;
            m_clk  = r;
            m_tick = r;
            if (r) m_state = 1;
        end else if (m_cnt != m_n - 1) begin
            m_cnt  = m_cnt + 1;
            m_clk  = (m_cnt < h);
            m_tick = 0;
            if (m_state == 1 && xfer && ok) begin
                m_pend  = ratio;
                m_state = 2;
            end
        end else begin
            if (m_state == 2) m_n = m_pend;
            else if (xfer && ok) m_n = ratio;
            m_cnt   = 0;
            m_clk   = r;
            m_tick  = r;
            m_state = r ? 1 : 0;
        end
    endtask

    // drive at negedge, predict, compare just after the following posedge
    task automatic cycle(input logic a_run, input logic a_valid, input logic [7:0] a_ratio);
        exp_t e;
        run       = a_run;
        cfg_valid = a_valid;
        cfg_ratio = a_ratio;
        model_step(a_run, a_valid, int'(a_ratio));
        e.clk_out = m_clk;
        e.tick    = m_tick;
        e.busy    = (m_state != 0);
        e.ready   = (m_state != 2);
        e.err     = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("clk_out", clk_out, e.clk_out);
        check("tick", tick, e.tick);
        check("busy", busy, e.busy);
        check("cfg_ready", cfg_ready, e.ready);
        check("cfg_err", cfg_err, e.err);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic run_cycles(input logic a_run, input int n);
        for (int i = 0; i < n; i++) cycle(a_run, 1'b0, 8'd0);
    endtask

    task automatic wait_cnt(input int target);
        int i;
        i = 0;
        while (!(m_state != 0 && m_cnt == target) && i < 300) begin
            cycle(1'b1, 1'b0, 8'd0);
            i++;
        end
        if (i >= 300) check("wait_cnt_timeout", m_cnt, target);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (m_state != 0 && i < 300) begin
            cycle(1'b0, 1'b0, 8'd0);
            i++;
        end
        if (i >= 300) check("wait_idle_timeout", m_state, 0);
    endtask

    task automatic check_reset_values();
        check("rst_clk_out", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_ratio = 8'd0;
        model_reset();
        #2;
        check_reset_values();
        @(negedge clk);
        reset = 1'b1;

        // default N=4, one-cycle start latency
        cycle(1'b1, 1'b0, 8'd0);
        check("start_latency_clk_out", clk_out, 1);
        run_cycles(1'b1, 11);
        wait_idle();

        // ratio 3 loaded in IDLE
        cycle(1'b0, 1'b1, 8'd3);
        run_cycles(1'b1, 10);
        wait_idle();

        // back to 4, then change to 6 in the 2nd cycle of a period
        cycle(1'b0, 1'b1, 8'd4);
        run_cycles(1'b1, 6);
        wait_cnt(1);
        cycle(1'b1, 1'b1, 8'd6);
        check("pend_ready_low", cfg_ready, 0);
        run_cycles(1'b1, 20);

        // illegal ratios while running
        cycle(1'b1, 1'b1, 8'd1);
        run_cycles(1'b1, 8);
        cycle(1'b1, 1'b1, 8'd0);
        run_cycles(1'b1, 8);

        // stop at cnt=1, then run glitch inside a period
        wait_cnt(1);
        run_cycles(1'b0, 8);
        check("stopped_busy", busy, 0);
        run_cycles(1'b1, 3);
        wait_cnt(1);
        cycle(1'b0, 1'b0, 8'd0);
        run_cycles(1'b1, 14);
        check("glitch_still_busy", busy, 1);

        // largest ratio: counter must not wrap
        wait_idle();
        cycle(1'b0, 1'b1, 8'd255);
        run_cycles(1'b1, 512);
        wait_idle();

        // random mix of run, transfers and ratios
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                  8'($urandom_range(0, 7)));
        end
        wait_idle();

        // async reset mid-period with a pending ratio
        cycle(1'b0, 1'b1, 8'd4);
        cycle(1'b1, 1'b0, 8'd0);
        wait_cnt(1);
        cycle(1'b1, 1'b1, 8'd8);
        check("pre_rst_clk_out", clk_out, 0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        run_cycles(1'b1, 12);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_div_ctrl.md
Name: clock_div_ctrl

Overview:
Run-time controller for the team's integer clock divider. It owns the divide counter and sequences start/stop and ratio changes through a valid/ready configuration handshake. A new ratio takes effect only on a period boundary, so clk_out never shows a runt pulse. It sits between the register/config logic and any logic clocked or enabled by the divided clock.

Parameters:
COUNT_REG_SIZE, 8, width of the ratio and of the internal counter
DEFAULT_RATIO, 4, ratio loaded at reset; must be >= 2 and < 2**COUNT_REG_SIZE

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
run  in  1  level; 1 = divider should run, 0 = stop at end of current period
cfg_valid  in  1  new ratio offered
cfg_ratio  in  COUNT_REG_SIZE  requested divide ratio N
cfg_ready  out  1  controller can accept a ratio this cycle
cfg_err  out  1  one-cycle pulse: accepted ratio was illegal (N<2) and was discarded
clk_out  out  1  divided clock (registered)
tick  out  1  one-cycle pulse coincident with each rising edge of clk_out
busy  out  1  1 while in RUN or PEND

Behaviour:
- Reset (reset=0, async): state=IDLE, ratio=DEFAULT_RATIO, cnt=0, clk_out=0, tick=0, cfg_err=0, cfg_ready=1, busy=0.
- Notation: N = active ratio; H = (N+1)>>1 = high-phase length. Period = N clk cycles; clk_out is high for H cycles and low for N-H cycles (N=4 gives 2/2, N=3 gives 2/1).
- Handshake: a transfer occurs when cfg_valid && cfg_ready on a rising clk edge.
  - cfg_ready = 1 in IDLE and RUN, and 0 in PEND.
  - If cfg_ratio < 2: the transfer completes, cfg_err=1 on the next cycle, and the ratio and state are unchanged.
- IDLE:
  - clk_out=0, cnt=0.
  - A legal transfer updates N on the next edge.
  - If run=1: on the next edge go to RUN with cnt<=0, clk_out<=1, tick<=1.
  - If a transfer and run=1 occur in the same cycle, the new N is used for the first period.
- RUN (and PEND), each edge:
  - If cnt != N-1: cnt<=cnt+1, clk_out<=(cnt+1 < H), tick<=0.
  - If cnt == N-1 (boundary):
    - A pending ratio, if any, is loaded into N first.
    - If run=1: cnt<=0, clk_out<=1, tick<=1, and the state is RUN.
    - If run=0: go to IDLE with clk_out<=0, cnt<=0.
- A legal transfer in RUN moves the state to PEND and stores the ratio as pending. The current period completes with the old N.
- run is sampled only at the boundary. Deasserting and reasserting run within one period has no effect.
- Simultaneous stop and pending ratio: the ratio is loaded and the state goes to IDLE, so the next run uses the new N.
- Counter width: COUNT_REG_SIZE. For N = 2**COUNT_REG_SIZE-1, cnt never overflows.
- The latency from run rising in IDLE to clk_out=1 is exactly 1 cycle.

Decomposition:
- The shared package/header clock_div_pkg holds:
  - state encodings IDLE=2'd0, RUN=2'd1, PEND=2'd2
  - MIN_RATIO=2
- One sub-module, clock_div_core: the counter and clk_out/tick generation. Its inputs are the enable, the N input and load-at-boundary; its output is the boundary flag.
- clock_div_ctrl keeps the FSM, the handshake, the pending register and error detection.

Test Plan:
- Reset defaults, then run=1: clk_out rises 1 cycle later and shows a 2-high/2-low pattern (N=4). tick pulses every 4 cycles, and busy=1.
- In IDLE, send cfg_ratio=3 then run=1: the pattern is high 2, low 1, with period 3. cfg_ready stays 1.
- While running at N=4, send cfg_ratio=6 in the 2nd cycle of a period:
  - cfg_ready=0 until the boundary.
  - The current period stays 4 cycles; the next period is 6 cycles (3 high, 3 low).
  - cfg_ready returns to 1.
- Send cfg_ratio=1 and separately cfg_ratio=0: each produces a single cfg_err pulse, and the ratio and clk_out period are unchanged.
- Deassert run at cnt=1 with N=4: clk_out finishes the period and then holds 0, busy=0. A run pulse low-then-high within one period does not stop the divider.
- Assert reset mid-period (cnt=2, clk_out=0, pending ratio 8): all outputs are immediately at reset values, N=DEFAULT_RATIO, and the pending ratio is discarded.
